// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the mem_responder memory slave.
// Access modes, the FSM state type and the byte-lane steering functions.
package mem_pkg;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_SBYTE = 2'b01;
    localparam logic [1:0] MODE_UBYTE = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Load result from a stored word; word accesses ignore the lane.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  mode,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [31:0] res;
        b = 8'(word >> {lane, 3'b000});
        unique case (mode)
            MODE_WORD:  res = word;
            MODE_SBYTE: res = {{24{b[7]}}, b};
            MODE_UBYTE: res = {24'h0, b};
            default:    res = 32'h0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] mode, input logic [1:0] lane);
        return (mode == MODE_WORD) ? 4'hf : 4'(4'b0001 << lane);
    endfunction

    // Byte stores replicate wdata[7:0] so the byte enable alone picks the lane.
    function automatic logic [31:0] store_data(input logic [1:0] mode, input logic [31:0] wdata);
        return (mode == MODE_WORD) ? wdata : {4{wdata[7:0]}};
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables
// and a registered read port; contents are never reset.
module mem_responder_ram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding request, IDLE/WAIT/RESP FSM.
// Define MEM_MISALIGN_TRAP_EN to reject word accesses with addr[1:0] != 0.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WaitLast = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    lane_q, lane_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;

    logic          addr_oor, misalign, req_bad, accept;
    logic          ram_en, ram_commit;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;

    always_comb begin
        addr_oor = |(req_addr >> (AW + 2));
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = (req_mode == MODE_WORD) && (req_addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        req_bad = (req_mode == MODE_RSVD) || addr_oor || misalign;
        accept  = req_valid && (state_q == StIdle);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        mode_d  = mode_q;
        lane_d  = lane_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    write_d = req_write;
                    mode_d  = req_mode;
                    lane_d  = req_addr[1:0];
                    idx_d   = req_addr[AW+1:2];
                    wdata_d = req_wdata;
                    err_d   = req_bad;
                    cnt_d   = 4'd0;
                    state_d = (LATENCY > 1) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q == WaitLast) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Outputs are registered, so they follow the state being entered.
        req_ready_d  = (state_d == StIdle);
        resp_valid_d = (state_d == StResp);
        resp_err_d   = (state_d == StResp) && err_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            mode_q       <= mode_d;
            lane_q       <= lane_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Loads read at acceptance so data is ready in RESP; stores commit at the end of RESP.
    always_comb begin
        ram_commit = (state_q == StResp) && write_q && !err_q && !reset;
        ram_en     = (accept && !req_write && !req_bad) || ram_commit;
        ram_addr   = (state_q == StIdle) ? req_addr[AW+1:2] : idx_q;
        ram_be     = ram_commit ? store_be(mode_q, lane_q) : 4'h0;
        ram_wdata  = store_data(mode_q, wdata_q);
    end

    mem_responder_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = (resp_valid_q && !write_q && !resp_err_q)
                        ? load_extract(ram_rdata, mode_q, lane_q) : 32'h0;

endmodule
